load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side memory access controller for the MEMORY ACCESS stage. Accepts one load or store at a time from the pipeline over a valid/ready handshake, and checks alignment and func3. It drives a byte-enabled, variable-latency req/ack port toward data memory, then returns a sign- or zero-extended load result or store completion. A per-access timeout counter guards against a memory that never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles memReq may stay high without memAck before the access aborts (1..65535)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- reqValid  input  1  pipeline presents an access
- reqReady  output  1  unit can accept an access
- reqIsStore  input  1  1 = store, 0 = load
- func3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  byte address
- storeData  input  32  store source data, right-justified
- respValid  output  1  one-cycle completion pulse
- respData  output  32  extended load data; 0 for stores and errors
- respError  output  1  with respValid: misaligned, illegal func3, or timeout
- memReq  output  1  memory request
- memWrite  output  1  1 = write
- memAddress  output  32  word address: address[31:2], 2'b00
- memByteEnable  output  4  lane enables, bit i = byte i
- memWriteData  output  32  lane-replicated write data
- memAck  input  1  memory completes the request this cycle
- memReadData  input  32  read word, valid when memAck=1

## Operation
- The FSM has three states: IDLE, ACCESS and RESPOND. reqReady=1 only in IDLE.
- On acceptance (reqValid & reqReady), the unit registers reqIsStore, func3, address[1:0] and the formatted memory-side fields.
- The access is legal if func3 is legal and the alignment check passes:
  - Legal loads: func3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Alignment: H needs address[0]=0. W needs address[1:0]=00. B has no requirement.
- Legal access: IDLE -> ACCESS. memReq=1, timeout counter cleared.
- Illegal access: IDLE -> RESPOND with respError=1. No memory access is issued.
- Byte enables:
  - B: 0001 << address[1:0]
  - H: 0011 << address[1:0]
  - W: 1111
  - Loads drive the same enables.
- Write data:
  - SB: {4{storeData[7:0]}}
  - SH: {2{storeData[15:0]}}
  - SW: storeData
  - Loads: memWriteData=0.
- ACCESS state:
  - memReq and all mem* fields are held constant until memAck=1 is sampled.
  - On memAck, go to RESPOND. For loads, capture memReadData >> (address[1:0]*8), then extend per func3: 000 sign-extend byte, 001 sign-extend half, 100/101 zero-extend, 010 pass through.
  - The counter increments each ACCESS cycle without ack. If it reaches TIMEOUT_CYCLES, drop memReq and go to RESPOND with respError=1 and respData=0.
  - memAck and timeout in the same cycle: the ack wins.
- RESPOND state: respValid=1 for exactly one cycle, then IDLE.
- memAck outside ACCESS is ignored.

## Timing
- Reset values: FSM IDLE; memReq, memWrite, respValid, respError = 0; respData, memAddress, memByteEnable, memWriteData = 0; counter = 0. reqReady=0 while reset is low.
- Reset asserted mid-access clears memReq asynchronously. The in-flight access is dropped and no response is produced.
- Accept in cycle N -> memReq high from cycle N+1 (registered).
- memAck in cycle N+1 -> respValid in cycle N+2. Minimum accept-to-response latency is 2 cycles; each ack wait cycle adds 1.
- Illegal access accepted in cycle N -> respValid with respError in cycle N+1. memReq is never raised.
- reqReady returns high in the cycle after respValid, so back-to-back throughput is one access per 3 cycles minimum.
- Timeout: memReq is high for exactly TIMEOUT_CYCLES cycles, and respValid/respError assert the following cycle.
- respData and respError are valid only while respValid=1. They are 0 otherwise.

## Test plan
- SW, address 0x104, storeData 0xDEADBEEF, ack 1 cycle after memReq -> memAddress 0x104, memByteEnable 1111, memWriteData 0xDEADBEEF, respValid 3 cycles after accept, respError 0.
- SB, address 0x107, storeData 0x000000A5 -> memByteEnable 1000, memWriteData 0xA5A5A5A5, memAddress 0x104.
- LB at 0x203 with memReadData 0x80FF0011 -> respData 0xFFFFFF80. LBU -> 0x00000080. LH at 0x202 -> 0xFFFF80FF. LHU -> 0x000080FF.
- LW at 0x102 -> no memReq, respValid next cycle with respError=1, respData 0. Store with func3 100 -> same behavior.
- TIMEOUT_CYCLES=4, memAck held 0 -> memReq high exactly 4 cycles, then respError=1. Then ack on the 4th cycle -> normal completion with respError 0.
- Assert reset during ACCESS with 3 wait cycles elapsed -> memReq 0 immediately, no respValid. After release, reqReady 1 and a new LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory port bundle
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqIsStore;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [3:0]  memByteEnable;
    logic [31:0] memWriteData;
    logic        memAck;
    logic [31:0] memReadData;
    modport slave (
        input  reqValid, reqIsStore, func3, address, storeData, memAck, memReadData,
        output reqReady, respValid, respData, respError,
               memReq, memWrite, memAddress, memByteEnable, memWriteData
    );
    modport master (
        output reqValid, reqIsStore, func3, address, storeData, memAck, memReadData,
        input  reqReady, respValid, respData, respError,
               memReq, memWrite, memAddress, memByteEnable, memWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller with timeout toward data memory
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clock,
    input logic reset,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2;
    logic [1:0]  state;
    logic        st_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_q;
    logic [31:0] maddr_q, wd_q, data_q;
    logic [3:0]  be_q;
    logic [15:0] cnt;
    logic        legal, aligned, f3_ok;
    logic [3:0]  be;
    logic [31:0] wd, sh, ext;
    // request decode: legality, lane enables, replicated write data
    always_comb begin
        f3_ok   = bus.reqIsStore ? (bus.func3 inside {3'b000, 3'b001, 3'b010})
                                 : (bus.func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        aligned = bus.func3[1:0] == 2'b01 ? ~bus.address[0] :
                  bus.func3[1:0] == 2'b10 ? bus.address[1:0] == 2'b00 : 1'b1;
        legal   = f3_ok & aligned;
        be      = bus.func3[1:0] == 2'b00 ? 4'b0001 << bus.address[1:0] :
                  bus.func3[1:0] == 2'b01 ? 4'b0011 << bus.address[1:0] : 4'b1111;
        wd      = !bus.reqIsStore ? 32'd0 :
                  bus.func3[1:0] == 2'b00 ? {4{bus.storeData[7:0]}} :
                  bus.func3[1:0] == 2'b01 ? {2{bus.storeData[15:0]}} : bus.storeData;
        sh      = bus.memReadData >> {addr_q, 3'b000};
        ext     = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                  f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                  f3_q == 3'b100 ? {24'd0, sh[7:0]} :
                  f3_q == 3'b101 ? {16'd0, sh[15:0]} : sh;
    end
    // access FSM: accept in IDLE, wait for ack or timeout in ACCESS, pulse response in RESPOND
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 2'd0;
            maddr_q <= 32'd0;
            wd_q    <= 32'd0;
            be_q    <= 4'd0;
            data_q  <= 32'd0;
            cnt     <= 16'd0;
        end else if (state == IDLE) begin
            if (bus.reqValid) begin
                state   <= legal ? ACCESS : RESPOND;
                st_q    <= bus.reqIsStore;
                err_q   <= ~legal;
                f3_q    <= bus.func3;
                addr_q  <= bus.address[1:0];
                maddr_q <= {bus.address[31:2], 2'b00};
                wd_q    <= wd;
                be_q    <= be;
                data_q  <= 32'd0;
                cnt     <= 16'd0;
            end
        end else if (state == ACCESS) begin
            if (bus.memAck) begin
                state  <= RESPOND;
                err_q  <= 1'b0;
                data_q <= st_q ? 32'd0 : ext;
            end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                state  <= RESPOND;
                err_q  <= 1'b1;
                data_q <= 32'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            state  <= IDLE;
            err_q  <= 1'b0;
            data_q <= 32'd0;
        end
    end
    assign bus.reqReady      = (state == IDLE) & reset;
    assign bus.memReq        = state == ACCESS;
    assign bus.memWrite      = (state == ACCESS) & st_q;
    assign bus.memAddress    = maddr_q;
    assign bus.memByteEnable = be_q;
    assign bus.memWriteData  = wd_q;
    assign bus.respValid     = state == RESPOND;
    assign bus.respError     = (state == RESPOND) & err_q;
    assign bus.respData      = state == RESPOND ? data_q : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit with a 4-cycle timeout
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    load_store_unit_if bus();
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int waits,
                          input logic [31:0] rd, input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] data, input logic err);
        chk({tag, ".ready"}, 32'(bus.reqReady), 32'd1);
        bus.reqValid = 1'b1; bus.reqIsStore = st; bus.func3 = f3;
        bus.address = a; bus.storeData = sd;
        step();
        bus.reqValid = 1'b0;
        if (!err) begin
            chk({tag, ".memReq"}, 32'(bus.memReq), 32'd1);
            chk({tag, ".memWrite"}, 32'(bus.memWrite), 32'(st));
            chk({tag, ".memAddress"}, bus.memAddress, {a[31:2], 2'b00});
            chk({tag, ".be"}, 32'(bus.memByteEnable), 32'(be));
            chk({tag, ".wdata"}, bus.memWriteData, wd);
            for (int i = 0; i < waits; i++) begin
                chk({tag, ".hold"}, 32'(bus.memReq), 32'd1);
                chk({tag, ".noresp"}, 32'(bus.respValid), 32'd0);
                step();
            end
            bus.memAck = 1'b1; bus.memReadData = rd;
            step();
            bus.memAck = 1'b0;
        end
        chk({tag, ".respValid"}, 32'(bus.respValid), 32'd1);
        chk({tag, ".respError"}, 32'(bus.respError), 32'(err));
        chk({tag, ".respData"}, bus.respData, data);
        chk({tag, ".reqDrop"}, 32'(bus.memReq), 32'd0);
        step();
        chk({tag, ".pulse"}, 32'(bus.respValid), 32'd0);
        chk({tag, ".dataClr"}, bus.respData, 32'd0);
        chk({tag, ".readyBack"}, 32'(bus.reqReady), 32'd1);
    endtask
    initial begin
        bus.reqValid = 1'b0; bus.reqIsStore = 1'b0; bus.func3 = 3'd0;
        bus.address = 32'd0; bus.storeData = 32'd0;
        bus.memAck = 1'b0; bus.memReadData = 32'd0;
        #1;
        chk("rst.ready", 32'(bus.reqReady), 32'd0);
        chk("rst.memReq", 32'(bus.memReq), 32'd0);
        chk("rst.memWrite", 32'(bus.memWrite), 32'd0);
        chk("rst.respValid", 32'(bus.respValid), 32'd0);
        chk("rst.memAddress", bus.memAddress, 32'd0);
        chk("rst.be", 32'(bus.memByteEnable), 32'd0);
        chk("rst.wdata", bus.memWriteData, 32'd0);
        step(); step();
        reset = 1'b1;
        step();
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        chk("stray_ack.resp", 32'(bus.respValid), 32'd0);
        chk("stray_ack.memReq", 32'(bus.memReq), 32'd0);
        access("sw", 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        access("sb", 1'b1, 3'b000, 32'h107, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
        access("sh", 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0);
        access("lb", 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF0011, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
        access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF0011, 4'b1000, 32'h0, 32'h00000080, 1'b0);
        access("lh", 1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80FF0011, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0);
        access("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF0011, 4'b1100, 32'h0, 32'h000080FF, 1'b0);
        access("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        access("sh_mis", 1'b1, 3'b001, 32'h101, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        access("st_f3", 1'b1, 3'b100, 32'h100, 32'h11223344, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        access("ld_f3", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        bus.reqValid = 1'b1; bus.reqIsStore = 1'b0; bus.func3 = 3'b010; bus.address = 32'h100;
        step();
        bus.reqValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to.memReq", 32'(bus.memReq), 32'd1);
            chk("to.noresp", 32'(bus.respValid), 32'd0);
            step();
        end
        chk("to.dropped", 32'(bus.memReq), 32'd0);
        chk("to.respValid", 32'(bus.respValid), 32'd1);
        chk("to.respError", 32'(bus.respError), 32'd1);
        chk("to.respData", bus.respData, 32'd0);
        step();
        chk("to.idle", 32'(bus.reqReady), 32'd1);
        access("ack_last", 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'h12345678, 4'b1111, 32'h0, 32'h12345678, 1'b0);
        bus.reqValid = 1'b1; bus.reqIsStore = 1'b0; bus.func3 = 3'b010; bus.address = 32'h300;
        step();
        bus.reqValid = 1'b0;
        step(); step(); step();
        chk("rs.before", 32'(bus.memReq), 32'd1);
        reset = 1'b0;
        #1;
        chk("rs.memReq", 32'(bus.memReq), 32'd0);
        chk("rs.ready", 32'(bus.reqReady), 32'd0);
        step();
        chk("rs.noresp", 32'(bus.respValid), 32'd0);
        reset = 1'b1;
        step();
        chk("rs.noresp2", 32'(bus.respValid), 32'd0);
        access("post_rst", 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
